// File: rtl/jk_excite_ctrl_pkg.sv
// Shared encodings for the JK excitation controller: opcodes, FSM states and
// the default register width.
package jk_excite_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

endpackage : jk_excite_ctrl_pkg

// File: rtl/jk_excite_ctrl_if.sv
// Command/status bundle of the JK excitation controller; the requester uses
// the master view and the controller the slave view.
interface jk_excite_ctrl_if
    import jk_excite_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] din;
    logic             cmd_ready;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd, din,
        input  cmd_ready, j, k, q, busy, done
    );

    modport slave (
        input  cmd_valid, cmd, din,
        output cmd_ready, j, k, q, busy, done
    );

endinterface : jk_excite_ctrl_if

// File: rtl/jk_excite_ctrl_jk_cell.sv
// Single JK flip-flop: 00 hold, 10 set, 01 reset, 11 toggle; async reset to 0.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule : jk_cell

// File: rtl/jk_excite_ctrl.sv
// Command-driven register built from JK cells: the FSM converts each
// LOAD/CLEAR/UP/DOWN step into per-bit J/K excitation.
module jk_excite_ctrl
    import jk_excite_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    jk_excite_ctrl_if.slave     bus
);

    state_e           state, state_nxt;
    op_e              op_r;
    logic [WIDTH-1:0] din_r;
    logic [WIDTH-1:0] step_cnt, step_nxt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j, k, q;
    logic             accept;
    logic             exec;
    logic             cmd_ready, busy, done;

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_LOAD;
            din_r    <= '0;
            step_cnt <= '0;
        end else begin
            step_cnt <= step_nxt;
            if (accept) begin
                op_r  <= op_e'(bus.cmd);
                din_r <= bus.din;
            end
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        exec      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd == OP_LOAD || bus.cmd == OP_CLEAR) begin
                        state_nxt = ST_EXEC;
                        step_nxt  = WIDTH'(1);
                    end else if (bus.din == '0) begin
                        state_nxt = ST_ACK;
                        step_nxt  = '0;
                    end else begin
                        state_nxt = ST_EXEC;
                        step_nxt  = bus.din;
                    end
                end
            end
            ST_EXEC: begin
                busy     = 1'b1;
                exec     = 1'b1;
                step_nxt = step_cnt - WIDTH'(1);
                if (step_cnt == WIDTH'(1)) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Value the cells should hold after this EXEC cycle.
    always_comb begin
        target = q;
        case (op_r)
            OP_LOAD:  target = din_r;
            OP_CLEAR: target = '0;
            OP_UP:    target = q + WIDTH'(1);
            OP_DOWN:  target = q - WIDTH'(1);
            default:  target = q;
        endcase
    end

    // Excitation with don't-cares resolved to 0: set only rising bits,
    // reset only falling bits.
    assign j = exec ? (target & ~q) : '0;
    assign k = exec ? (~target & q) : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.j         = j;
    assign bus.k         = k;
    assign bus.q         = q;

endmodule : jk_excite_ctrl

// File: tb/tb_jk_excite_ctrl.sv
// Randomized bench for jk_excite_ctrl against an arithmetic model of the
// register value, excitation table and command latency.
module tb_jk_excite_ctrl;
    import jk_excite_ctrl_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] q_model;

    jk_excite_ctrl_if #(.WIDTH(W)) bus ();

    jk_excite_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] step_target(input logic [1:0] op, input logic [W-1:0] d,
                                                 input logic [W-1:0] cur);
        int v;
        v = int'(cur);
        case (op)
            OP_LOAD:  v = int'(d);
            OP_CLEAR: v = 0;
            OP_UP:    v = (v + 1) % (1 << W);
            default:  v = (v + (1 << W) - 1) % (1 << W);
        endcase
        return W'(v);
    endfunction

    // Cycles from the accept edge to the edge that starts the done cycle.
    function automatic int exec_cycles(input logic [1:0] op, input logic [W-1:0] d);
        int lat;
        if (op == OP_LOAD || op == OP_CLEAR) lat = 2;
        else if (d == 0)                     lat = 1;
        else                                 lat = int'(d) + 1;
        return lat - 1;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d, input bit hold,
                           input logic [1:0] hold_op, input logic [W-1:0] hold_din);
        logic [W-1:0] tgt, ej, ek;
        int  n;
        bit  got_done;
        bus.cmd_valid = 1'b1;
        bus.cmd       = op;
        bus.din       = d;
        check("ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            bus.cmd = hold_op;
            bus.din = hold_din;
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd       = 2'($urandom_range(0, 3));
            bus.din       = W'($urandom_range(0, 15));
        end
        n        = 0;
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                check("busy_exec", 32'(bus.busy), 32'd1);
                check("ready_exec", 32'(bus.cmd_ready), 32'd0);
                check("q_exec", 32'(bus.q), 32'(q_model));
                tgt = step_target(op, d, q_model);
                for (int b = 0; b < W; b++) begin
                    ej[b] = (q_model[b] == 1'b0) && (tgt[b] == 1'b1);
                    ek[b] = (q_model[b] == 1'b1) && (tgt[b] == 1'b0);
                end
                check("j_exec", 32'(bus.j), 32'(ej));
                check("k_exec", 32'(bus.k), 32'(ek));
                q_model = tgt;
                n++;
                @(posedge clk);
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("latency", 32'(n), 32'(exec_cycles(op, d)));
        check("q_ack", 32'(bus.q), 32'(q_model));
        check("busy_ack", 32'(bus.busy), 32'd0);
        check("ready_ack", 32'(bus.cmd_ready), 32'd0);
        check("jk_ack", 32'({bus.j, bus.k}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_back", 32'(bus.cmd_ready), 32'd1);
        check("done_back", 32'(bus.done), 32'd0);
        check("jk_idle", 32'({bus.j, bus.k}), 32'd0);
        check("q_idle", 32'(bus.q), 32'(q_model));
    endtask

    initial begin
        logic [1:0]   cur_op, nxt_op;
        logic [W-1:0] cur_d, nxt_d;
        bit           hold;
        n_checks      = 0;
        n_fail        = 0;
        q_model       = '0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = OP_LOAD;
        bus.din       = '0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        check("rst_jk", 32'({bus.j, bus.k}), 32'd0);
        rst = 1'b0;

        // Directed sequence: loads, wrap-around up/down and a zero-step command.
        run_cmd(OP_LOAD, 4'b1010, 1'b0, OP_LOAD, '0);
        check("load_1010", 32'(bus.q), 32'b1010);
        run_cmd(OP_LOAD, 4'b0101, 1'b0, OP_LOAD, '0);
        run_cmd(OP_LOAD, 4'b1110, 1'b0, OP_LOAD, '0);
        run_cmd(OP_UP, 4'd3, 1'b0, OP_LOAD, '0);
        check("up_wrap", 32'(bus.q), 32'b0001);
        run_cmd(OP_DOWN, 4'd2, 1'b0, OP_LOAD, '0);
        check("down_wrap", 32'(bus.q), 32'b1111);
        run_cmd(OP_UP, 4'd0, 1'b0, OP_LOAD, '0);

        // A request held through EXEC is taken only once the block is idle again.
        run_cmd(OP_UP, 4'd5, 1'b1, OP_CLEAR, 4'd9);
        run_cmd(OP_CLEAR, 4'd9, 1'b0, OP_LOAD, '0);

        // Reset during the third EXEC cycle of a long UP.
        bus.cmd_valid = 1'b1;
        bus.cmd       = OP_UP;
        bus.din       = 4'd8;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_q", 32'(bus.q), 32'd0);
        check("async_ready", 32'(bus.cmd_ready), 32'd1);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_jk", 32'({bus.j, bus.k}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_done_rst", 32'(bus.done), 32'd0);
        end
        rst     = 1'b0;
        q_model = '0;
        run_cmd(OP_LOAD, W'($urandom_range(1, 15)), 1'b0, OP_LOAD, '0);

        // Random commands, sometimes with the next request held during EXEC.
        cur_op = 2'($urandom_range(0, 3));
        cur_d  = (cur_op >= 2) ? W'($urandom_range(0, 6)) : W'($urandom_range(0, 15));
        for (int i = 0; i < 30; i++) begin
            nxt_op = 2'($urandom_range(0, 3));
            nxt_d  = (nxt_op >= 2) ? W'($urandom_range(0, 6)) : W'($urandom_range(0, 15));
            hold   = ($urandom_range(0, 2) == 0);
            run_cmd(cur_op, cur_d, hold, nxt_op, nxt_d);
            cur_op = nxt_op;
            cur_d  = nxt_d;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_jk_excite_ctrl

// File: doc/jk_excite_ctrl.md
JK_EXCITE_CTRL -- requirements
Module: jk_excite_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd  input  2  opcode: 00 LOAD, 01 CLEAR, 10 UP, 11 DOWN.
REQ-006 din  input  WIDTH  LOAD value, or step count for UP/DOWN.
REQ-007 cmd_ready  output  1  high when a command can be accepted.
REQ-008 j  output  WIDTH  J excitation driven into the JK cells this cycle.
REQ-009 k  output  WIDTH  K excitation driven into the JK cells this cycle.
REQ-010 q  output  WIDTH  current register value, taken from the JK cells.
REQ-011 busy  output  1  high in the EXEC state.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC and ACK.
REQ-014 cmd_ready SHALL be 1 only in IDLE; the block accepts a command on a rising edge in IDLE with cmd_valid=1.
REQ-015 On acceptance, the block SHALL latch cmd and din; cmd_valid outside IDLE SHALL be ignored, not queued.
REQ-016 For LOAD or CLEAR, IDLE SHALL go to EXEC for one cycle; target = din for LOAD, 0 for CLEAR.
REQ-017 For UP or DOWN with din != 0, EXEC SHALL last exactly din cycles.
  - Each EXEC cycle: target = q+1 (UP) or q-1 (DOWN), mod 2^WIDTH, wrapping 15->0 and 0->15.
REQ-018 For UP or DOWN with din == 0, IDLE SHALL go directly to ACK and q SHALL be unchanged.
REQ-019 In EXEC, j and k SHALL follow the JK excitation table, bit by bit, with don't-cares resolved to 0:
  - q 0->0: j=0, k=0
  - q 0->1: j=1, k=0
  - q 1->0: j=0, k=1
  - q 1->1: j=0, k=0
REQ-020 j and k SHALL be all-zero in IDLE and ACK, so the cells hold.
REQ-021 q SHALL update only through the JK cells, on the edge ending each EXEC cycle.
REQ-022 An internal step counter SHALL decrement once per EXEC cycle; EXEC SHALL exit to ACK on the edge where the counter reaches 0.
REQ-023 ACK SHALL last one cycle with done=1, and q SHALL already show the final value; ACK SHALL then return to IDLE.
REQ-024 Latency SHALL be accept edge + 2 cycles to done for LOAD/CLEAR, + (din+1) cycles for UP/DOWN with din>0, and + 1 cycle for step 0.
REQ-025 busy SHALL be 1 only in EXEC, and done SHALL be 1 only in ACK.

Reset
REQ-026 While rst=1, the block SHALL immediately force: state IDLE, q=0, j=0, k=0, busy=0, done=0, step counter 0, cmd_ready=1.
REQ-027 Reset asserted mid-EXEC SHALL abort the command with no done pulse; the first edge after release SHALL be able to accept a new command.

Structure
REQ-028 A shared package/include SHALL hold the opcode encodings, the state encodings and the WIDTH default.
REQ-029 Sub-module jk_cell SHALL be instantiated WIDTH times.
  - Ports: clk, rst, j, k, q.
  - Async active-high reset to 0.
  - Behaviour: 00 hold, 10 set, 01 reset, 11 toggle.

Verification
REQ-030 Reset, then LOAD din=1010 -> j=1010, k=0000 in EXEC; q=1010 and done=1 two cycles after the accept edge.
REQ-031 q=1010, LOAD din=0101 -> j=0101, k=1010; q=0101 after one EXEC cycle.
REQ-032 q=1110, UP din=3 -> busy for 3 cycles, q sequence 1111, 0000, 0001 (wrap), then done=1.
REQ-033 q=0001, DOWN din=2 -> q sequence 0000, 1111; UP din=0 -> done next cycle with q unchanged.
REQ-034 Hold cmd_valid=1 with a new cmd throughout EXEC -> second command not accepted until IDLE; cmd_ready=0 while busy.
REQ-035 UP din=8, assert rst in the 3rd EXEC cycle -> q=0 asynchronously, no done pulse, cmd_ready=1 after release.
